prescaled_counter_bank: RTL and testbench
=========================================

// Module: prescaled_counter_bank
// PURPOSE
//   Parametrised bank of NUM_CH event counters with a per-channel runtime prescaler.
//   Each accepted event (En=1) goes to the one channel chosen by Slt.
//   Supports wrap or saturate on overflow, a sticky overflow flag, per-channel
//   synchronous clear, and a one-cycle increment strobe for downstream logic.
//   Sits beside the datapath as a general-purpose event/performance counter block.
// PARAMETERS
//   NUM_CH   4   number of counter channels (>=1)
//   CNT_W    64  width of each event counter
//   PRE_W    2   width of prescaler counter and divisor
//   DIV_RST  0   divisor value loaded into every channel at reset
//   SAT      0   overflow mode: 0 = wrap to zero, 1 = saturate at all-ones
//   localparam SEL_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1
// PORTS
//   Clk       in   1             clock; all state updates on posedge
//   Reset_n   in   1             asynchronous, active-low reset
//   En        in   1             event valid for the channel on Slt
//   Slt       in   SEL_W         channel select for En and Clr
//   Clr       in   1             synchronous clear of channel Slt
//   CfgWe     in   1             divisor write strobe
//   CfgCh     in   SEL_W         channel for the divisor write
//   CfgDiv    in   PRE_W         new divisor: increment every CfgDiv+1 events
//   Count     out  NUM_CH*CNT_W  channel i in bits [i*CNT_W +: CNT_W]
//   Tick      out  NUM_CH        1-cycle pulse: Count[i] changed by increment
//   Ovf       out  NUM_CH        sticky overflow flag per channel
// BEHAVIOUR
//   - Reset_n=0 immediately, with no clock needed: Count=0, pre[i]=0, div[i]=DIV_RST, Tick=0, Ovf=0.
//     This applies mid-operation too. State is held while reset is low.
//   - Event on channel i: En=1 and Slt==i and Clr=0 at a posedge.
//     Slt>=NUM_CH: En and Clr are ignored; no state changes.
//   - Prescale: on an event, if pre[i]==div[i] then pre[i]<=0 and Count[i] increments.
//     Otherwise pre[i]<=pre[i]+1. Divisor d therefore gives 1 increment per d+1 events.
//   - Latency: the new Count is visible right after the sampling edge.
//     Tick[i] is registered and high for exactly that cycle.
//     Tick[i]=0 on any cycle with no increment, including a saturated hold.
//   - Overflow, increment attempted with Count[i] all-ones:
//       SAT=0: Count[i]<=0, Ovf[i]<=1, Tick[i]=1.
//       SAT=1: Count[i] holds all-ones, Ovf[i]<=1, Tick[i]=0.
//     Ovf[i] clears only on reset or on Clr of channel i.
//   - Clr=1 with Slt==i: Count[i], pre[i], Ovf[i] <= 0. div[i] is unchanged.
//     Clr has priority over a same-cycle En, so the event is dropped.
//   - Config: CfgWe=1 and CfgCh==i gives div[i]<=CfgDiv and pre[i]<=0.
//     CfgCh>=NUM_CH is ignored.
//   - Config together with an event on the same channel:
//     the increment decision uses the old div and pre; pre[i] still ends at 0.
//   - Config together with Clr on the same channel: both apply; div takes CfgDiv.
//   - En=0: no channel changes, whatever Slt is.
//   - Channels are fully independent. Arithmetic is unsigned and modulo width.
// TESTING
//   1 NUM_CH=4, reset then En=1,Slt=2 for 5 cycles -> Count[2]=5, others 0;
//     Tick[2] pulses 5 times.
//   2 CfgWe,CfgCh=1,CfgDiv=3, then 8 events on ch1 -> Count[1]=1 after event 4,
//     2 after event 8; Tick[1] pulses twice.
//   3 CNT_W=4,SAT=0, 17 events ch0 -> Count 15 after 15 events, 0 with Ovf[0]=1
//     after 16, 1 after 17. With SAT=1 -> Count stays 15, Ovf[0]=1, no Tick
//     after event 15.
//   4 Count[3]=7, Clr=1,En=1,Slt=3 -> Count[3]=0, Ovf[3]=0, pre[3]=0;
//     next event with div=0 -> Count[3]=1.
//   5 NUM_CH=3: En=1,Slt=3 for 4 cycles -> no change; En=0 with Slt toggling
//     -> no change.
//   6 Count[0]=9 mid-stream, drop Reset_n between edges -> Count[0]=0 and Ovf=0
//     before the next edge; after release, div back to DIV_RST.

Source files
------------

// File: rtl/prescaled_counter_bank.sv
// Bank of NUM_CH event counters, each with its own runtime-programmable prescaler.
// Events, clears and divisor writes are steered to one channel by select inputs.
module prescaled_counter_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 64,
    parameter int PRE_W   = 2,
    parameter int DIV_RST = 0,
    parameter int SAT     = 0,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    En,
    input  logic [SEL_W-1:0]        Slt,
    input  logic                    Clr,
    input  logic                    CfgWe,
    input  logic [SEL_W-1:0]        CfgCh,
    input  logic [PRE_W-1:0]        CfgDiv,
    output logic [NUM_CH*CNT_W-1:0] Count,
    output logic [NUM_CH-1:0]       Tick,
    output logic [NUM_CH-1:0]       Ovf
);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [PRE_W-1:0]  pre_q [NUM_CH];
    logic [PRE_W-1:0]  pre_d [NUM_CH];
    logic [PRE_W-1:0]  div_q [NUM_CH];
    logic [PRE_W-1:0]  div_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] sel_hit, cfg_hit;

    function automatic logic cnt_full(input logic [CNT_W-1:0] c);
        return &c;
    endfunction

    // Out-of-range selects match no channel, so they are ignored for free.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
        assign sel_hit[g] = (Slt == SEL_W'(g));
        assign cfg_hit[g] = (CfgCh == SEL_W'(g));
        assign Count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign Tick = tick_q;
    assign Ovf  = ovf_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            pre_d[i]  = pre_q[i];
            div_d[i]  = div_q[i];
            ovf_d[i]  = ovf_q[i];
            tick_d[i] = 1'b0;
            if (Clr && sel_hit[i]) begin
                cnt_d[i] = '0;
                pre_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (En && sel_hit[i]) begin
                if (pre_q[i] == div_q[i]) begin
                    pre_d[i] = '0;
                    if (cnt_full(cnt_q[i])) begin
                        ovf_d[i] = 1'b1;
                        if (SAT == 0) begin
                            cnt_d[i]  = '0;
                            tick_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                        tick_d[i] = 1'b1;
                    end
                end else begin
                    pre_d[i] = pre_q[i] + PRE_W'(1);
                end
            end
            // Divisor write overrides the prescaler phase after the increment decision.
            if (CfgWe && cfg_hit[i]) begin
                div_d[i] = CfgDiv;
                pre_d[i] = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                pre_q[i] <= '0;
                div_q[i] <= PRE_W'(DIV_RST);
            end
            tick_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                pre_q[i] <= pre_d[i];
                div_q[i] <= div_d[i];
            end
            tick_q <= tick_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_prescaled_counter_bank.sv
// Drives two differently-parameterised counter banks from one stimulus stream and
// compares both against a behavioural model of the event/prescale/overflow rules.
module tb_prescaled_counter_bank;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        En, Clr, CfgWe;
    logic [1:0]  Slt, CfgCh, CfgDiv;
    logic [15:0] Count_a;
    logic [3:0]  Tick_a, Ovf_a;
    logic [11:0] Count_b;
    logic [2:0]  Tick_b, Ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: index 0 = wrap bank (4 ch, DIV_RST 0), 1 = saturating bank (3 ch, DIV_RST 1)
    int NCH    [2] = '{4, 3};
    int SATP   [2] = '{0, 1};
    int DIVR   [2] = '{0, 1};
    int m_cnt  [2][4];
    int m_pre  [2][4];
    int m_div  [2][4];
    bit m_ovf  [2][4];
    bit m_tick [2][4];

    prescaled_counter_bank #(.NUM_CH(4), .CNT_W(4), .PRE_W(2), .DIV_RST(0), .SAT(0)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Slt(Slt), .Clr(Clr),
        .CfgWe(CfgWe), .CfgCh(CfgCh), .CfgDiv(CfgDiv),
        .Count(Count_a), .Tick(Tick_a), .Ovf(Ovf_a)
    );

    prescaled_counter_bank #(.NUM_CH(3), .CNT_W(4), .PRE_W(2), .DIV_RST(1), .SAT(1)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Slt(Slt), .Clr(Clr),
        .CfgWe(CfgWe), .CfgCh(CfgCh), .CfgDiv(CfgDiv),
        .Count(Count_b), .Tick(Tick_b), .Ovf(Ovf_b)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cnt_obs(input int k, input int ch);
        return (k == 0) ? Count_a[ch*4 +: 4] : Count_b[ch*4 +: 4];
    endfunction

    function automatic logic tick_obs(input int k, input int ch);
        return (k == 0) ? Tick_a[ch] : Tick_b[ch];
    endfunction

    function automatic logic ovf_obs(input int k, input int ch);
        return (k == 0) ? Ovf_a[ch] : Ovf_b[ch];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) begin
                m_cnt[k][c]  = 0;
                m_pre[k][c]  = 0;
                m_div[k][c]  = DIVR[k];
                m_ovf[k][c]  = 1'b0;
                m_tick[k][c] = 1'b0;
            end
    endtask

    // One clock of the rules: d+1 accepted events per increment, clear wins over event.
    task automatic model_step();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH[k]; c++) begin
                bit cfg_here;
                cfg_here = CfgWe && (int'(CfgCh) == c);
                m_tick[k][c] = 1'b0;
                if (Clr && int'(Slt) == c) begin
                    m_cnt[k][c] = 0;
                    m_pre[k][c] = 0;
                    m_ovf[k][c] = 1'b0;
                end else if (En && int'(Slt) == c) begin
                    m_pre[k][c] = m_pre[k][c] + 1;
                    if (m_pre[k][c] > m_div[k][c]) begin
                        m_pre[k][c] = 0;
                        if (m_cnt[k][c] + 1 > 15) begin
                            m_ovf[k][c] = 1'b1;
                            if (SATP[k] == 0) begin
                                m_cnt[k][c]  = 0;
                                m_tick[k][c] = 1'b1;
                            end
                        end else begin
                            m_cnt[k][c]  = m_cnt[k][c] + 1;
                            m_tick[k][c] = 1'b1;
                        end
                    end
                end
                if (cfg_here) begin
                    m_div[k][c] = int'(CfgDiv);
                    m_pre[k][c] = 0;
                end
            end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH[k]; c++) begin
                check($sformatf("cnt%0d_%0d", k, c), 64'(cnt_obs(k, c)), 64'(m_cnt[k][c]));
                check($sformatf("tick%0d_%0d", k, c), 64'(tick_obs(k, c)), 64'(m_tick[k][c]));
                check($sformatf("ovf%0d_%0d", k, c), 64'(ovf_obs(k, c)), 64'(m_ovf[k][c]));
            end
    endtask

    task automatic cycle(input logic en, input logic [1:0] slt, input logic clr,
                         input logic we, input logic [1:0] ch, input logic [1:0] dv);
        En = en; Slt = slt; Clr = clr; CfgWe = we; CfgCh = ch; CfgDiv = dv;
        @(posedge Clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ev(input logic [1:0] slt);
        cycle(1'b1, slt, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic async_reset_pulse();
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge Clk);
        #1;
        check_all();
        Reset_n = 1'b1;
    endtask

    int ticks;

    initial begin
        Reset_n = 1'b0;
        En = 0; Slt = 0; Clr = 0; CfgWe = 0; CfgCh = 0; CfgDiv = 0;
        model_reset();
        #12;
        check_all();
        Reset_n = 1'b1;

        // 5 events on channel 2
        ticks = 0;
        for (int n = 0; n < 5; n++) begin
            ev(2'd2);
            ticks += int'(tick_obs(0, 2));
        end
        check("t1_cnt2", 64'(cnt_obs(0, 2)), 64'd5);
        check("t1_ticks", 64'(ticks), 64'd5);
        check("t1_cnt0", 64'(cnt_obs(0, 0)), 64'd0);

        // divisor 3 on channel 1
        cycle(1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 2'd3);
        ticks = 0;
        for (int n = 1; n <= 8; n++) begin
            ev(2'd1);
            ticks += int'(tick_obs(0, 1));
            if (n == 4) check("t2_cnt_ev4", 64'(cnt_obs(0, 1)), 64'd1);
        end
        check("t2_cnt_ev8", 64'(cnt_obs(0, 1)), 64'd2);
        check("t2_ticks", 64'(ticks), 64'd2);
        check("t2_cnt_b", 64'(cnt_obs(1, 1)), 64'd2);

        // overflow on channel 0, wrap vs saturate
        cycle(1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 2'd0);
        for (int n = 1; n <= 17; n++) begin
            ev(2'd0);
            if (n == 15) begin
                check("t3_a_15", 64'(cnt_obs(0, 0)), 64'd15);
                check("t3_b_15", 64'(cnt_obs(1, 0)), 64'd15);
            end
            if (n == 16) begin
                check("t3_a_wrap", 64'(cnt_obs(0, 0)), 64'd0);
                check("t3_a_ovf", 64'(ovf_obs(0, 0)), 64'd1);
                check("t3_a_tick", 64'(tick_obs(0, 0)), 64'd1);
                check("t3_b_sat", 64'(cnt_obs(1, 0)), 64'd15);
                check("t3_b_ovf", 64'(ovf_obs(1, 0)), 64'd1);
                check("t3_b_tick", 64'(tick_obs(1, 0)), 64'd0);
            end
        end
        check("t3_a_17", 64'(cnt_obs(0, 0)), 64'd1);
        check("t3_b_17", 64'(cnt_obs(1, 0)), 64'd15);

        // clear beats a same-cycle event on channel 3
        cycle(1'b0, 2'd3, 1'b1, 1'b0, 2'd0, 2'd0);
        for (int n = 0; n < 7; n++) ev(2'd3);
        check("t4_cnt7", 64'(cnt_obs(0, 3)), 64'd7);
        cycle(1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 2'd0);
        check("t4_clr", 64'(cnt_obs(0, 3)), 64'd0);
        ev(2'd3);
        check("t4_next", 64'(cnt_obs(0, 3)), 64'd1);

        // out-of-range select and idle toggling
        for (int n = 0; n < 4; n++) ev(2'd3);
        for (int n = 0; n < 4; n++) cycle(1'b0, 2'(n), 1'b0, 1'b0, 2'd0, 2'd0);

        // async reset mid-stream
        cycle(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0);
        for (int n = 0; n < 9; n++) ev(2'd0);
        check("t6_cnt9", 64'(cnt_obs(0, 0)), 64'd9);
        cycle(1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd2);
        async_reset_pulse();
        check("t6_rst_cnt", 64'(cnt_obs(0, 0)), 64'd0);
        ev(2'd0);
        ev(2'd0);
        check("t6_div_a", 64'(cnt_obs(0, 0)), 64'd2);
        check("t6_div_b", 64'(cnt_obs(1, 0)), 64'd1);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset_pulse();
            end else begin
                cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
